fetch_inst_queue: RTL

- Receiving end of the fetch-to-decode path.
- Accepts 8-byte-aligned two-slot fetch packets (PC plus the two instruction words returned by the icache for that PC) and stores the valid words in a circular instruction buffer.
- Presents up to two oldest instructions per cycle to decode and pops however many decode consumes.
- Sits between the fetch/icache response and the decode stage; decouples fetch bandwidth from decode stalls and absorbs flushes.

---
 rtl/fetch_inst_queue_pkg.sv | 23 ++
 rtl/fetch_inst_queue_ptr_ctrl.sv | 77 +++++++
 rtl/fetch_inst_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_inst_queue_pkg.sv
// fetch_inst_queue_pkg: shared types and constants for the fetch-to-decode instruction queue.
// Revision: 1.0
`default_nettype none

package fetch_inst_queue_pkg;

    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  mask;
        logic [31:0] inst0;
        logic [31:0] inst1;
    } fetch_packet_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_inst_queue_ptr_ctrl.sv
// iq_ptr_ctrl: read/write pointers, occupancy count, in_ready and enqueue/dequeue amounts.
// Revision: 1.0
`default_nettype none

module iq_ptr_ctrl
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [1:0]       in_mask_i,
    input  logic [1:0]       deq_num_i,
    output logic             in_ready_o,
    output logic             enq_fire_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W:0]   count_o
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [1:0]       n_in, n_out, deq_clamp;

    // Ready depends only on registered count so enqueue never waits on decode.
    assign in_ready_o = (count_q <= (PTR_W+1)'(DEPTH - FETCH_WIDTH));
    assign enq_fire_o = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        n_in      = 2'd0;
        n_out     = 2'd0;
        deq_clamp = (deq_num_i == 2'd3) ? 2'd2 : deq_num_i;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (enq_fire_o) begin
            n_in = 2'({1'b0, in_mask_i[0]}) + 2'({1'b0, in_mask_i[1]});
        end
        if (count_q < (PTR_W+1)'(deq_clamp)) begin
            n_out = count_q[1:0];
        end else begin
            n_out = deq_clamp;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(n_in);
            rd_ptr_d = rd_ptr_q + PTR_W'(n_out);
            count_d  = count_q + (PTR_W+1)'(n_in) - (PTR_W+1)'(n_out);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign wr_ptr_o = wr_ptr_q;
    assign count_o  = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: circular instruction buffer between icache response and decode.
// Optional macro FETCH_IQ_PERF_EN enables saturating full/empty cycle counters.
`default_nettype none

module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [1:0]  in_mask,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    output logic [1:0]  out_valid,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    input  logic [1:0]  deq_num,
    output logic [31:0] perf_full_cycles,
    output logic [31:0] perf_empty_cycles
);

    fetch_packet_t    pkt;
    iq_entry_t        mem_q [DEPTH];
    logic             enq_fire;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_p1, wr_ptr_p1;
    logic [PTR_W:0]   count;

    assign pkt = '{pc: in_pc, mask: in_mask, inst0: in_inst0, inst1: in_inst1};

    iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_mask_i  (pkt.mask),
        .deq_num_i  (deq_num),
        .in_ready_o (in_ready),
        .enq_fire_o (enq_fire),
        .rd_ptr_o   (rd_ptr),
        .wr_ptr_o   (wr_ptr),
        .count_o    (count)
    );

    assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
    assign rd_ptr_p1 = rd_ptr + PTR_W'(1);

    // Valid slots are compacted: a lone slot1 lands at wr_ptr with pc+4.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            case (pkt.mask)
                2'b11: begin
                    mem_q[wr_ptr]    <= '{pc: pkt.pc, inst: pkt.inst0};
                    mem_q[wr_ptr_p1] <= '{pc: pkt.pc + 32'd4, inst: pkt.inst1};
                end
                2'b01:   mem_q[wr_ptr] <= '{pc: pkt.pc, inst: pkt.inst0};
                2'b10:   mem_q[wr_ptr] <= '{pc: pkt.pc + 32'd4, inst: pkt.inst1};
                default: ;
            endcase
        end
    end

    assign out_valid = {count >= (PTR_W+1)'(2), count != '0};
    assign out_pc0   = mem_q[rd_ptr].pc;
    assign out_inst0 = mem_q[rd_ptr].inst;
    assign out_pc1   = mem_q[rd_ptr_p1].pc;
    assign out_inst1 = mem_q[rd_ptr_p1].inst;

`ifdef FETCH_IQ_PERF_EN
    logic [31:0] perf_full_q, perf_empty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (in_valid && !in_ready && perf_full_q != '1) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if (count == '0 && !flush && perf_empty_q != '1) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`else
    assign perf_full_cycles  = 32'd0;
    assign perf_empty_cycles = 32'd0;
`endif

endmodule

`default_nettype wire
